// File: rtl/rv_pkg.sv
// Shared types and field positions for the byte-serial RV32E fetch stage.
package rv_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    localparam int INSTR_W   = 32;
    localparam int RS1_LSB   = 15;
    localparam int RS2_LSB   = 20;
    localparam int RD_LSB    = 7;
    localparam int REG_IDX_W = 4;

    // RV32E only has x0..x15, so the top bit of any 5-bit register field flags an illegal index.
    function automatic logic reg_out_of_range(input logic [INSTR_W-1:0] w);
        return w[RS1_LSB+REG_IDX_W] | w[RS2_LSB+REG_IDX_W] | w[RD_LSB+REG_IDX_W];
    endfunction

endpackage

// File: rtl/rv_byte_assembler.sv
// Collects four little-endian bytes into a 32-bit word; done pulses with the fourth load.
module rv_byte_assembler
    import rv_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [7:0]         byte_i,
    output logic               done_o,
    output logic [1:0]         byte_cnt_o,
    output logic [INSTR_W-1:0] word_o
);

    logic [1:0]         cnt_q, cnt_d;
    logic [INSTR_W-1:0] word_q, word_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear_i) begin
            cnt_d = 2'd0;
        end else if (load_i) begin
            word_d[{cnt_q, 3'b000} +: 8] = byte_i;
            cnt_d                        = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign done_o     = load_i & ~clear_i & (cnt_q == 2'd3);
    assign byte_cnt_o = cnt_q;
    assign word_o     = word_q;

endmodule

// File: rtl/rv_fetch_serial.sv
// Byte-serial RV32E fetch: four byte reads per instruction, then hold until downstream accepts.
module rv_fetch_serial
    import rv_pkg::*;
#(
    parameter int              PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 mem_req,
    output logic [PC_W-1:0]      mem_addr,
    input  logic                 mem_ack,
    input  logic [7:0]           mem_rdata,
    input  logic                 redirect_valid,
    input  logic [PC_W-1:0]      redirect_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [INSTR_W-1:0]   instr,
    output logic [PC_W-1:0]      instr_pc,
    output logic [REG_IDX_W-1:0] rs1,
    output logic [REG_IDX_W-1:0] rs2,
    output logic [REG_IDX_W-1:0] rd,
    output logic                 reg_illegal
);

    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] instr_pc_q, instr_pc_d;
    logic            valid_q, valid_d;
    logic            blank_q, blank_d;

    logic            byte_load;
    logic            asm_done;
    logic [1:0]      byte_cnt;

    // blank_q suppresses the request for one cycle after reset or redirect.
    assign mem_req   = (state_q == FETCH) & ~blank_q;
    assign mem_addr  = pc_q + PC_W'(byte_cnt);
    assign byte_load = mem_req & mem_ack & ~redirect_valid;

    rv_byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .load_i     (byte_load),
        .clear_i    (redirect_valid),
        .byte_i     (mem_rdata),
        .done_o     (asm_done),
        .byte_cnt_o (byte_cnt),
        .word_o     (instr)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        blank_d    = 1'b0;
        if (redirect_valid) begin
            pc_d    = redirect_pc & ALIGN_MASK;
            valid_d = 1'b0;
            state_d = FETCH;
            blank_d = 1'b1;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (asm_done) begin
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        state_d    = HOLD;
                    end
                end
                HOLD: begin
                    if (valid_q & instr_ready) begin
                        valid_d = 1'b0;
                        pc_d    = pc_q + PC_W'(4);
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC & ALIGN_MASK;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            blank_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            blank_q    <= blank_d;
        end
    end

    assign instr_valid = valid_q;
    assign instr_pc    = instr_pc_q;
    assign rs1         = instr[RS1_LSB +: REG_IDX_W];
    assign rs2         = instr[RS2_LSB +: REG_IDX_W];
    assign rd          = instr[RD_LSB +: REG_IDX_W];
    assign reg_illegal = reg_out_of_range(instr);

endmodule

// File: tb/tb_rv_fetch_serial.sv
// Bench for rv_fetch_serial: byte memory model, vector table, scoreboard of expected instructions.
module tb_rv_fetch_serial;

    typedef struct {
        logic [31:0] word;
        logic [11:0] pc;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, rst_w;
    logic        mem_ack, instr_ready, redirect_valid;
    logic [11:0] redirect_pc;
    logic [7:0]  mem_rdata, mem_rdata_w;

    logic        mem_req, instr_valid, reg_illegal;
    logic [11:0] mem_addr, instr_pc;
    logic [31:0] instr;
    logic [3:0]  rs1, rs2, rd;

    logic        mem_req_w, instr_valid_w, reg_illegal_w;
    logic [11:0] mem_addr_w, instr_pc_w;
    logic [31:0] instr_w;
    logic [3:0]  rs1_w, rs2_w, rd_w;

    logic [7:0]  mem [0:4095];
    exp_t        sb[$];
    logic [11:0] aq[$];
    exp_t        vecs[5];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    rv_fetch_serial #(.PC_W(12), .RESET_PC(12'h000)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .rs1(rs1), .rs2(rs2), .rd(rd), .reg_illegal(reg_illegal)
    );

    rv_fetch_serial #(.PC_W(12), .RESET_PC(12'hFFC)) dut_w (
        .clk(clk), .rst(rst_w), .mem_req(mem_req_w), .mem_addr(mem_addr_w), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata_w), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid_w), .instr_ready(instr_ready), .instr(instr_w), .instr_pc(instr_pc_w),
        .rs1(rs1_w), .rs2(rs2_w), .rd(rd_w), .reg_illegal(reg_illegal_w)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mem_rdata   = mem[mem_addr];
        mem_rdata_w = mem[mem_addr_w];
    endtask

    task automatic write_word(input logic [11:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[a + 12'(i)] = w[8*i +: 8];
    endtask

    task automatic cmp_item(input string tag, input exp_t e, input logic [31:0] w, input logic [11:0] pc,
                            input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2, input logic il);
        chk({tag, "_instr"}, w, e.word);
        chk({tag, "_pc"}, 32'(pc), 32'(e.pc));
        chk({tag, "_rd"}, 32'(d), 32'(e.rd));
        chk({tag, "_rs1"}, 32'(s1), 32'(e.rs1));
        chk({tag, "_rs2"}, 32'(s2), 32'(e.rs2));
        chk({tag, "_ill"}, 32'(il), 32'(e.ill));
    endtask

    initial begin
        exp_t        e;
        logic        p_req, p_ack;
        logic [11:0] p_addr;
        int          cyc;

        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        write_word(12'h000, 32'h00500093);
        vecs[0] = '{32'h01F08F93, 12'h004, 4'hF, 4'h1, 4'hF, 1'b1};
        vecs[1] = '{32'h002081B3, 12'h008, 4'h3, 4'h1, 4'h2, 1'b0};
        vecs[2] = '{32'hFFFFFFFF, 12'h00C, 4'hF, 4'hF, 4'hF, 1'b1};
        vecs[3] = '{32'h00000000, 12'h010, 4'h0, 4'h0, 4'h0, 1'b0};
        vecs[4] = '{32'h00F70733, 12'h014, 4'hE, 4'hE, 4'hF, 1'b0};
        foreach (vecs[i]) write_word(vecs[i].pc, vecs[i].word);
        write_word(12'h120, 32'h40B50533);
        write_word(12'hFFC, 32'h00F70733);

        rst = 1'b1; rst_w = 1'b1; mem_ack = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; mem_rdata = '0; mem_rdata_w = '0;
        repeat (3) tick();
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", 32'(instr_pc), 0);
        chk("rst_fields", {19'd0, rd, rs1, rs2, reg_illegal}, 0);
        chk("rst_w_valid", {instr_w, 31'd0, instr_valid_w} == 63'd0 ? 32'd0 : 32'd1, 0);

        // First fetch: one blank cycle, then addresses 0..3, valid on cycle 5.
        rst = 1'b0;
        chk("c0_req", 32'(mem_req), 0);
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("f_req", 32'(mem_req), 1);
            chk("f_addr", 32'(mem_addr), i);
        end
        tick();
        chk("c5_valid", 32'(instr_valid), 1);
        e = '{32'h00500093, 12'h000, 4'h1, 4'h0, 4'h5, 1'b0};
        cmp_item("first", e, instr, instr_pc, rd, rs1, rs2, reg_illegal);

        // Hold with ready low; stray acks must be ignored.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_req", 32'(mem_req), 0);
            chk("hold_valid", 32'(instr_valid), 1);
            chk("hold_instr", instr, 32'h00500093);
        end
        instr_ready = 1'b1;
        tick();
        chk("next_req", 32'(mem_req), 1);
        chk("next_addr", 32'(mem_addr), 4);
        chk("next_valid", 32'(instr_valid), 0);

        // Table-driven run with random ack/ready; scoreboard pops on each handshake.
        foreach (vecs[i]) sb.push_back(vecs[i]);
        cyc = 0;
        while (sb.size() > 0 && cyc < 400) begin
            mem_ack     = 1'($urandom_range(0, 1));
            instr_ready = 1'($urandom_range(0, 1));
            if (instr_valid && instr_ready) begin
                e = sb.pop_front();
                cmp_item("tbl", e, instr, instr_pc, rd, rs1, rs2, reg_illegal);
            end
            p_req = mem_req; p_addr = mem_addr; p_ack = mem_ack;
            tick();
            cyc++;
            if (p_req && !p_ack) chk("req_stable", {19'd0, mem_req, mem_addr}, {19'd0, 1'b1, p_addr});
        end
        if (sb.size() != 0) begin
            chk("tbl_timeout", 32'(sb.size()), 0);
            sb.delete();
        end

        // Redirect at byte_cnt=2 with an ack in the same cycle.
        rst = 1'b1; instr_ready = 1'b0; mem_ack = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("rdr_pre_addr", 32'(mem_addr), 2);
        redirect_valid = 1'b1; redirect_pc = 12'h123;
        sb.push_back('{32'h40B50533, 12'h120, 4'hA, 4'hA, 4'hB, 1'b0});
        tick();
        redirect_valid = 1'b0;
        chk("rdr_blank_req", 32'(mem_req), 0);
        chk("rdr_blank_valid", 32'(instr_valid), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rdr_req", 32'(mem_req), 1);
            chk("rdr_addr", 32'(mem_addr), 32'h120 + i);
        end
        tick();
        chk("rdr_valid", 32'(instr_valid), 1);
        if (instr_valid && sb.size() > 0) begin
            e = sb.pop_front();
            cmp_item("rdr", e, instr, instr_pc, rd, rs1, rs2, reg_illegal);
        end
        sb.delete();

        // Reset while holding an instruction.
        tick(); tick();
        chk("hold2_valid", 32'(instr_valid), 1);
        rst = 1'b1;
        tick();
        chk("rsth_valid", 32'(instr_valid), 0);
        chk("rsth_req", 32'(mem_req), 0);
        chk("rsth_instr", instr, 0);
        rst = 1'b0;
        tick();
        chk("rsth_req2", 32'(mem_req), 1);
        chk("rsth_addr", 32'(mem_addr), 0);

        // PC wrap from 0xFFC on the second instance.
        rst = 1'b1; rst_w = 1'b0; mem_ack = 1'b1; instr_ready = 1'b1;
        chk("w_blank", 32'(mem_req_w), 0);
        sb.push_back('{32'h00F70733, 12'hFFC, 4'hE, 4'hE, 4'hF, 1'b0});
        sb.push_back('{32'h00500093, 12'h000, 4'h1, 4'h0, 4'h5, 1'b0});
        aq = '{12'hFFC, 12'hFFD, 12'hFFE, 12'hFFF, 12'h000, 12'h001, 12'h002, 12'h003};
        cyc = 0;
        while (sb.size() > 0 && cyc < 40) begin
            if (mem_req_w && aq.size() > 0) chk("wrap_addr", 32'(mem_addr_w), 32'(aq.pop_front()));
            if (instr_valid_w && instr_ready) begin
                e = sb.pop_front();
                cmp_item("wrap", e, instr_w, instr_pc_w, rd_w, rs1_w, rs2_w, reg_illegal_w);
            end
            tick();
            cyc++;
        end
        chk("wrap_done", 32'(sb.size() + aq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
